// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage MIPS pipeline.
// Sequences load-use bubbles, multi-cycle data-memory waits with a
// timeout, and MEM-stage taken-branch flushes. It drives the pipeline
// register enables and clears, and keeps saturating stall/flush counters.
//
// Handshake: the data memory is busy while EX/MEM holds a load or store
// and mem_ready_i is low. mem_ready_i high means the access completes in
// this cycle. No valid/ready pair exists beyond that single level signal.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_hold_o,
  output logic             idex_flush_o,
  output logic             exmem_hold_o,
  output logic             exmem_flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_mem_busy;
  logic w_br_taken;
  logic w_lu_hit;
  logic w_lu_eff;
  logic w_active;
  logic w_flush_evt;

  logic w_pc_write;
  logic w_pc_src;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_hold;
  logic w_idex_flush;
  logic w_exmem_hold;
  logic w_exmem_flush;

  // Hazard decode from the pipeline register contents.
  always_comb begin
    w_mem_busy  = (exmem_memread_i | exmem_memwrite_i) & ~mem_ready_i;
    w_br_taken  = exmem_branch_i & exmem_zero_i;
    w_lu_hit    = idex_memread_i & (idex_rt_i != 5'd0) &
                  ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    // ID/EX already carries the bubble while in LU_STALL, so a second
    // stall for the same pair would cost an extra cycle.
    w_lu_eff    = w_lu_hit & (r_state != ST_LU_STALL);
    w_active    = (r_state != ST_HALT);
    w_flush_evt = w_active & ~w_mem_busy & w_br_taken;
  end

  // State register; reset abandons any stall or wait in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection in priority order: memory busy, branch, load-use.
  always_comb begin
    w_next = ST_RUN;
    if (r_state == ST_HALT) begin
      w_next = ST_HALT;
    end else if (w_mem_busy) begin
      w_next = (r_wait_cnt == TIMEOUT_LAST) ? ST_HALT : ST_MEM_WAIT;
    end else if (w_br_taken) begin
      w_next = ST_RUN;
    end else if (w_lu_eff) begin
      w_next = ST_LU_STALL;
    end else begin
      w_next = ST_RUN;
    end
  end

  // Control outputs: zero-latency from state and inputs, forced in reset.
  always_comb begin
    w_pc_write    = 1'b1;
    w_pc_src      = 1'b0;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_hold   = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_hold  = 1'b0;
    w_exmem_flush = 1'b0;
    if (!rst_i) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (!w_active || w_mem_busy) begin
      // Freeze: every stage keeps its contents.
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_hold  = 1'b1;
      w_exmem_hold = 1'b1;
    end else if (w_br_taken) begin
      // Redirect fetch and squash the three younger instructions.
      w_pc_write    = 1'b1;
      w_pc_src      = 1'b1;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_lu_eff) begin
      // Hold PC and IF/ID, push a bubble into ID/EX.
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  // Memory-wait counter: counts consecutive busy cycles, frozen in HALT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= '0;
    end else if (w_active) begin
      if (w_mem_busy) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Sticky timeout flag, set on the edge that enters HALT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_next == ST_HALT) begin
      r_err <= 1'b1;
    end
  end

  // Stall counter: every edge with PC held, saturating at all ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Flush counter: one per taken-branch flush, saturating at all ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_flush_cnt <= '0;
    end else if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign pc_write_o    = w_pc_write;
  assign pc_src_o      = w_pc_src;
  assign ifid_write_o  = w_ifid_write;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_hold_o   = w_idex_hold;
  assign idex_flush_o  = w_idex_flush;
  assign exmem_hold_o  = w_exmem_hold;
  assign exmem_flush_o = w_exmem_flush;
  assign err_o         = r_err;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, register $0, memory wait,
// branch over load-use, timeout into HALT, and reset during a wait.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 16;
  localparam int WAIT_W      = 8;
  localparam int MEM_TIMEOUT = 200;

  // Control vector order:
  // {pc_write, pc_src, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_flush}
  localparam logic [7:0] C_DEF = 8'b1010_0000;
  localparam logic [7:0] C_FRZ = 8'b0000_1010;
  localparam logic [7:0] C_BR  = 8'b1111_0101;
  localparam logic [7:0] C_LU  = 8'b0000_0100;
  localparam logic [7:0] C_RST = 8'b0001_0101;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LU   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic             clk_i;
  logic             rst_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic             exmem_branch_i;
  logic             exmem_zero_i;
  logic             exmem_memread_i;
  logic             exmem_memwrite_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_src_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_hold_o;
  logic             idex_flush_o;
  logic             exmem_hold_o;
  logic             exmem_flush_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]       dbg_state_o;

  int n_pass  = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .WAIT_W      (WAIT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ifid_rs_i        (ifid_rs_i),
    .ifid_rt_i        (ifid_rt_i),
    .idex_memread_i   (idex_memread_i),
    .idex_rt_i        (idex_rt_i),
    .exmem_branch_i   (exmem_branch_i),
    .exmem_zero_i     (exmem_zero_i),
    .exmem_memread_i  (exmem_memread_i),
    .exmem_memwrite_i (exmem_memwrite_i),
    .mem_ready_i      (mem_ready_i),
    .pc_write_o       (pc_write_o),
    .pc_src_o         (pc_src_o),
    .ifid_write_o     (ifid_write_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_hold_o      (idex_hold_o),
    .idex_flush_o     (idex_flush_o),
    .exmem_hold_o     (exmem_hold_o),
    .exmem_flush_o    (exmem_flush_o),
    .err_o            (err_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock: rising edges at 5, 15, 25 ... ; stimulus changes on falling edges.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] ctrl_vec();
    return {pc_write_o, pc_src_o, ifid_write_o, ifid_flush_o,
            idex_hold_o, idex_flush_o, exmem_hold_o, exmem_flush_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    ifid_rs_i        = 5'd0;
    ifid_rt_i        = 5'd0;
    idex_memread_i   = 1'b0;
    idex_rt_i        = 5'd0;
    exmem_branch_i   = 1'b0;
    exmem_zero_i     = 1'b0;
    exmem_memread_i  = 1'b0;
    exmem_memwrite_i = 1'b0;
    mem_ready_i      = 1'b0;
  endtask

  // Advance to the next falling edge, i.e. past exactly one rising edge.
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  initial begin
    // ---------------- reset ----------------
    rst_i = 1'b0;
    idle_inputs();
    #12;
    chk("rst_ctrl", ctrl_vec(), C_RST);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_flush", flush_cnt_o, 0);
    chk("rst_state", dbg_state_o, S_RUN);
    next_cycle();
    rst_i = 1'b1;
    #1;
    chk("idle_ctrl", ctrl_vec(), C_DEF);

    // ---------------- load-use on rs ----------------
    next_cycle();
    idex_memread_i = 1'b1; idex_rt_i = 5'd2; ifid_rs_i = 5'd2;
    #1;
    chk("lu_ctrl", ctrl_vec(), C_LU);
    next_cycle();
    #1;
    // Same hazard pattern still visible, but masked in LU_STALL.
    chk("lu_state", dbg_state_o, S_LU);
    chk("lu_mask_ctrl", ctrl_vec(), C_DEF);
    next_cycle();
    idle_inputs();
    #1;
    chk("lu_back_run", dbg_state_o, S_RUN);
    chk("lu_stall_cnt", stall_cnt_o, 1);

    // ---------------- register $0 never stalls ----------------
    idex_memread_i = 1'b1; idex_rt_i = 5'd0; ifid_rt_i = 5'd0;
    #1;
    chk("r0_ctrl", ctrl_vec(), C_DEF);
    next_cycle();
    idle_inputs();
    #1;
    chk("r0_stall_cnt", stall_cnt_o, 1);

    // ---------------- memory wait, ready 3 cycles late ----------------
    exmem_memread_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frz%0d", i), ctrl_vec(), C_FRZ);
      next_cycle();
    end
    chk("mw_state", dbg_state_o, S_WAIT);
    mem_ready_i = 1'b1;
    #1;
    chk("mw_ready_ctrl", ctrl_vec(), C_DEF);
    next_cycle();
    idle_inputs();
    #1;
    // 1 from the load-use plus 3 freeze cycles.
    chk("mw_stall_cnt", stall_cnt_o, 4);
    chk("mw_state_run", dbg_state_o, S_RUN);

    // ---------------- branch not taken is transparent ----------------
    exmem_branch_i = 1'b1; exmem_zero_i = 1'b0;
    #1;
    chk("bnt_ctrl", ctrl_vec(), C_DEF);

    // ---------------- taken branch beats load-use ----------------
    next_cycle();
    exmem_branch_i = 1'b1; exmem_zero_i = 1'b1;
    idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rt_i = 5'd5;
    #1;
    chk("br_lu_ctrl", ctrl_vec(), C_BR);
    next_cycle();
    idle_inputs();
    #1;
    chk("br_flush_cnt", flush_cnt_o, 1);
    chk("br_stall_cnt", stall_cnt_o, 4);
    chk("br_state", dbg_state_o, S_RUN);

    // ---------------- memory busy beats load-use, then load-use from wait ----------------
    exmem_memwrite_i = 1'b1; mem_ready_i = 1'b0;
    idex_memread_i = 1'b1; idex_rt_i = 5'd7; ifid_rt_i = 5'd7;
    #1;
    chk("mb_lu_ctrl", ctrl_vec(), C_FRZ);
    next_cycle();
    mem_ready_i = 1'b1;
    #1;
    chk("wait_lu_ctrl", ctrl_vec(), C_LU);
    next_cycle();
    idle_inputs();
    #1;
    chk("wait_lu_state", dbg_state_o, S_LU);
    chk("wait_lu_stall_cnt", stall_cnt_o, 6);

    // ---------------- timeout into HALT ----------------
    exmem_memwrite_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      chk($sformatf("to_frz%0d", i), ctrl_vec(), C_FRZ);
      if (i == MEM_TIMEOUT - 1) chk("to_err_before", err_o, 0);
      next_cycle();
    end
    chk("to_state", dbg_state_o, S_HALT);
    chk("to_err", err_o, 1);
    // Memory completes and a taken branch appears: HALT ignores both.
    mem_ready_i = 1'b1; exmem_branch_i = 1'b1; exmem_zero_i = 1'b1;
    #1;
    chk("halt_ctrl", ctrl_vec(), C_FRZ);
    next_cycle();
    #1;
    chk("halt_state", dbg_state_o, S_HALT);
    chk("halt_err", err_o, 1);
    chk("halt_flush_cnt", flush_cnt_o, 1);
    // 6 earlier + 200 busy cycles + 1 HALT cycle.
    chk("halt_stall_cnt", stall_cnt_o, 207);

    // Asynchronous reset out of HALT, mid-cycle.
    #2;
    rst_i = 1'b0;
    #1;
    chk("halt_rst_err", err_o, 0);
    chk("halt_rst_stall", stall_cnt_o, 0);
    chk("halt_rst_flush", flush_cnt_o, 0);
    chk("halt_rst_ctrl", ctrl_vec(), C_RST);
    next_cycle();
    idle_inputs();
    rst_i = 1'b1;
    #1;
    chk("post_halt_ctrl", ctrl_vec(), C_DEF);

    // ---------------- reset during a memory wait ----------------
    next_cycle();
    exmem_memread_i = 1'b1; mem_ready_i = 1'b0;
    #1;
    chk("rmw_frz0", ctrl_vec(), C_FRZ);
    next_cycle();
    #1;
    chk("rmw_frz1", ctrl_vec(), C_FRZ);
    chk("rmw_state", dbg_state_o, S_WAIT);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rmw_rst_ctrl", ctrl_vec(), C_RST);
    chk("rmw_rst_state", dbg_state_o, S_RUN);
    chk("rmw_rst_stall", stall_cnt_o, 0);
    next_cycle();
    rst_i = 1'b1;
    exmem_memread_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    chk("rmw_new_access", ctrl_vec(), C_DEF);
    next_cycle();
    idle_inputs();
    #1;
    chk("rmw_stall_after", stall_cnt_o, 0);
    chk("rmw_state_after", dbg_state_o, S_RUN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
